jtframe_dual_wait_gate: RTL and testbench
=========================================

// Module: jtframe_dual_wait_gate
// PURPOSE
//  Stalls a two-phase CPU clock-enable pair (E/Q, 6809-style) while the CPU cannot be served:
//  shared-bus device busy, or a ROM fetch from SDRAM not yet ready.
//  Keeps E/Q strictly alternating across stalls and optionally replays swallowed pulses
//  so average CPU speed is preserved. Sits between the cen divider and the CPU core.
// PARAMETERS
//  DEVCNT    1   width of dev_busy (number of bus-sharing devices)
//  RECOVERY  1   1: replay missed pulses after a stall; 0: missed pulses are lost
//  MAXMISS   15  saturation value of missed-pulse counter (counter width = $clog2(MAXMISS+1))
// PORTS
//  clk       in   1        system clock; reset is synchronous, active-high
//  rst       in   1        synchronous reset, active-high
//  cen_in    in   2        raw enables {E,Q}: bit1=E, bit0=Q; one-clk pulses, alternating
//  cen_out   out  2        gated/recovered enables {E,Q} to CPU
//  gate      out  1        1 = CPU may run; 0 = stalled
//  dev_busy  in   DEVCNT   any bit high: shared memory owned by another device
//  rom_cs    in   1        CPU is accessing ROM
//  rom_ok    in   1        ROM data valid
// BEHAVIOUR
//  - stall = |dev_busy | (rom_cs & ~rom_ok); gate = ~stall (combinational, same cycle).
//  - State: nxt (expected next phase, E or Q), miss (saturating counter), last (cen_out pulsed prev clk).
//  - Reset: nxt=E, miss=0, last=0; cen_out=2'b00 while rst high; gate still follows stall.
//  - Per clock, evaluated in order:
//    * stall: cen_out=0; each cen_in pulse -> miss+1 (saturate at MAXMISS).
//    * !stall, cen_in pulse whose phase == nxt: pass it on cen_out; nxt toggles.
//    * !stall, cen_in pulse whose phase != nxt: swallowed; miss+1 (saturating); nxt unchanged.
//    * !stall, no cen_in pulse, RECOVERY=1, miss>0, last=0: emit one pulse of phase nxt;
//      nxt toggles; miss-1.
//    * otherwise cen_out=0.
//  - cen_in=2'b11 (protocol error): E handled as the incoming pulse, Q counted as missed.
//  - At most one cen_out bit high per clock; E and Q on cen_out always alternate, E first after reset.
//  - Recovered pulses never on adjacent clocks to another cen_out pulse (min one idle clk).
//  - miss saturates silently at MAXMISS; never wraps below 0.
//  - Stall asserted mid-recovery: recovery stops immediately, pulses again counted as missed.
//  - rom_cs low: rom_ok ignored. RECOVERY=0: miss held at 0, mismatched pulses just dropped.
// STRUCTURE
//  - Shared package jtframe_cen_pkg: localparams PH_E=1'b1, PH_Q=1'b0, bit indices CEN_E=1, CEN_Q=0.
//  - One sub-module: jtframe_satcnt (up/down saturating counter, params W, MAX) for miss.
//  - Rest flat: phase register, stall decode, output mux.
// TESTING
//  1. No stall, cen_in E,Q alternating every 4 clk -> cen_out identical to cen_in, gate=1.
//  2. rom_cs=1,rom_ok=0 for 2 E and 2 Q pulses -> cen_out 0, gate 0; after rom_ok=1 with
//     RECOVERY=1 -> 4 extra pulses E,Q,E,Q in idle clocks, each separated by >=1 idle clk.
//  3. Stall released when next incoming pulse is Q but nxt=E -> Q swallowed, miss+1, next E passed.
//  4. dev_busy=1 for 40 pulses, MAXMISS=15 -> exactly 15 recovered pulses afterwards.
//  5. RECOVERY=0, same stall as 2 -> no extra pulses; phase order preserved.
//  6. rst asserted mid-recovery -> cen_out 0 during rst; after release no replay, first out pulse is E.

Source files
------------

// File: rtl/jtframe_cen_pkg.sv
// Shared definitions for the E/Q clock-enable pair: phase encodings and the
// bit positions of E and Q inside a {E,Q} enable vector.
package jtframe_cen_pkg;

  localparam logic PH_E = 1'b1;
  localparam logic PH_Q = 1'b0;

  localparam int unsigned CEN_E = 1;
  localparam int unsigned CEN_Q = 0;

  typedef enum logic {
    PHASE_Q = PH_Q,
    PHASE_E = PH_E
  } phase_e;

  function automatic phase_e phase_flip(input phase_e p);
    return (p == PHASE_E) ? PHASE_Q : PHASE_E;
  endfunction

endpackage

// File: rtl/jtframe_satcnt.sv
// Up/down counter clamped to [0, MAX]. Increments take priority over decrement.
module jtframe_satcnt #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+1:0] sum_w;

  always_comb begin
    cnt_d = cnt_q;
    sum_w = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
    if (inc_i != 2'd0) begin
      cnt_d = (sum_w > (W+2)'(MAX)) ? W'(MAX) : sum_w[W-1:0];
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/jtframe_dual_wait_gate.sv
// Gates the E/Q enable pair while the shared bus or ROM is not available,
// keeping strict E/Q alternation and optionally replaying swallowed pulses.
module jtframe_dual_wait_gate
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned DEVCNT   = 1,
  parameter int unsigned RECOVERY = 1,
  parameter int unsigned MAXMISS  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cen_in,
  output logic [1:0]        cen_out,
  output logic              gate,
  input  logic [DEVCNT-1:0] dev_busy,
  input  logic              rom_cs,
  input  logic              rom_ok
);

  localparam int unsigned MW = (MAXMISS > 0) ? $clog2(MAXMISS + 1) : 1;

  logic          stall;
  phase_e        nxt_q, nxt_d;
  phase_e        in_ph;
  logic          last_q;
  logic [1:0]    cen_d;
  logic [1:0]    miss_inc;
  logic          miss_dec;
  logic [MW-1:0] miss;

  assign stall = |dev_busy | (rom_cs & ~rom_ok);
  assign gate  = ~stall;

  jtframe_satcnt #(
    .W   (MW),
    .MAX (MAXMISS)
  ) u_miss (
    .clk   (clk),
    .rst   (rst),
    .inc_i (miss_inc),
    .dec_i (miss_dec),
    .cnt_o (miss)
  );

  always_comb begin
    cen_d    = '0;
    nxt_d    = nxt_q;
    miss_inc = 2'd0;
    miss_dec = 1'b0;
    // With both bits set, E is the incoming pulse and Q is counted as missed
    in_ph    = cen_in[CEN_E] ? PHASE_E : PHASE_Q;
    if (stall) begin
      miss_inc = {1'b0, cen_in[CEN_E]} + {1'b0, cen_in[CEN_Q]};
    end else if (cen_in != 2'b00) begin
      if (in_ph == nxt_q) begin
        cen_d[(in_ph == PHASE_E) ? CEN_E : CEN_Q] = 1'b1;
        nxt_d = phase_flip(nxt_q);
      end else begin
        miss_inc = 2'd1;
      end
      if (cen_in == 2'b11) miss_inc = miss_inc + 2'd1;
    end else if (RECOVERY != 0 && miss != '0 && !last_q) begin
      cen_d[(nxt_q == PHASE_E) ? CEN_E : CEN_Q] = 1'b1;
      nxt_d    = phase_flip(nxt_q);
      miss_dec = 1'b1;
    end
    if (RECOVERY == 0) begin
      miss_inc = 2'd0;
      miss_dec = 1'b0;
    end
    if (rst) cen_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_q  <= PHASE_E;
      last_q <= 1'b0;
    end else begin
      nxt_q  <= nxt_d;
      last_q <= |cen_d;
    end
  end

  assign cen_out = cen_d;

endmodule

// File: tb/tb_jtframe_dual_wait_gate.sv
// Directed bench for jtframe_dual_wait_gate: one instance with replay enabled
// (two bus devices) and one with replay disabled.
module tb_jtframe_dual_wait_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cen_a, out_a, busy_a;
  logic       gate_a, rom_cs_a, rom_ok_a;
  logic [1:0] cen_b, out_b;
  logic [0:0] busy_b;
  logic       gate_b, rom_cs_b, rom_ok_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jtframe_dual_wait_gate #(
    .DEVCNT   (2),
    .RECOVERY (1),
    .MAXMISS  (15)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .cen_in   (cen_a),
    .cen_out  (out_a),
    .gate     (gate_a),
    .dev_busy (busy_a),
    .rom_cs   (rom_cs_a),
    .rom_ok   (rom_ok_a)
  );

  jtframe_dual_wait_gate #(
    .DEVCNT   (1),
    .RECOVERY (0),
    .MAXMISS  (15)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .cen_in   (cen_b),
    .cen_out  (out_b),
    .gate     (gate_b),
    .dev_busy (busy_b),
    .rom_cs   (rom_cs_b),
    .rom_ok   (rom_ok_b)
  );

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic adv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cen_a = 2'b10; busy_a = 2'b00; rom_cs_a = 1'b0; rom_ok_a = 1'b0;
    cen_b = 2'b00; busy_b = 1'b0;  rom_cs_b = 1'b0; rom_ok_b = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({out_a, gate_a} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_out: {cen_out,gate}=%b expected 001", {out_a, gate_a});
    end
    busy_a = 2'b01;
    #1;
    vectors++;
    if ({out_a, gate_a} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_gate: {cen_out,gate}=%b expected 000", {out_a, gate_a});
    end
    adv();
    adv();
    rst = 1'b0; busy_a = 2'b00; cen_a = 2'b00;
    #1;
    vectors++;
    if ({out_a, gate_a, out_b, gate_b} !== 6'b001001) begin
      miscompares++;
      $display("FAIL reset_release: a/b outputs=%b expected 001001", {out_a, gate_a, out_b, gate_b});
    end
    adv();
  endtask

  task automatic test_passthrough;
    logic [1:0] c;
    for (int i = 0; i < 32; i++) begin
      c = (i % 8 == 0) ? 2'b10 : (i % 8 == 4) ? 2'b01 : 2'b00;
      cen_a = c;
      #1;
      vectors++;
      if ({out_a, gate_a} !== {c, 1'b1}) begin
        miscompares++;
        $display("FAIL passthrough cyc %0d: {cen_out,gate}=%b expected %b", i, {out_a, gate_a}, {c, 1'b1});
      end
      adv();
    end
    cen_a = 2'b00;
  endtask

  task automatic test_rom_stall;
    logic [1:0] c;
    logic [1:0] rec [0:11];
    rec = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
            2'b00, 2'b00, 2'b00, 2'b00};
    rom_cs_a = 1'b1; rom_ok_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c = (i % 8 == 0) ? 2'b10 : (i % 8 == 4) ? 2'b01 : 2'b00;
      cen_a = c;
      #1;
      vectors++;
      if ({out_a, gate_a} !== 3'b000) begin
        miscompares++;
        $display("FAIL rom_stall cyc %0d: {cen_out,gate}=%b expected 000", i, {out_a, gate_a});
      end
      adv();
    end
    rom_ok_a = 1'b1; cen_a = 2'b00;
    for (int i = 0; i < 12; i++) begin
      #1;
      vectors++;
      if ({out_a, gate_a} !== {rec[i], 1'b1}) begin
        miscompares++;
        $display("FAIL rom_replay cyc %0d: {cen_out,gate}=%b expected %b", i, {out_a, gate_a}, {rec[i], 1'b1});
      end
      adv();
    end
    rom_cs_a = 1'b0; rom_ok_a = 1'b0;
    #1;
    vectors++;
    if (gate_a !== 1'b1) begin
      miscompares++;
      $display("FAIL rom_cs_low: gate=%b expected 1", gate_a);
    end
    adv();
  endtask

  task automatic test_mismatch;
    logic [1:0] cin [0:9];
    logic [1:0] exp [0:9];
    cin = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    exp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    busy_a = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cen_a = (i == 0) ? 2'b10 : 2'b00;
      #1;
      vectors++;
      if ({out_a, gate_a} !== 3'b000) begin
        miscompares++;
        $display("FAIL mismatch_stall cyc %0d: {cen_out,gate}=%b expected 000", i, {out_a, gate_a});
      end
      adv();
    end
    busy_a = 2'b00;
    for (int i = 0; i < 10; i++) begin
      cen_a = cin[i];
      #1;
      vectors++;
      if ({out_a, gate_a} !== {exp[i], 1'b1}) begin
        miscompares++;
        $display("FAIL mismatch cyc %0d: {cen_out,gate}=%b expected %b", i, {out_a, gate_a}, {exp[i], 1'b1});
      end
      adv();
    end
    cen_a = 2'b00;
  endtask

  task automatic test_protocol_error;
    logic [1:0] cin [0:4];
    logic [1:0] exp [0:4];
    cin = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      cen_a = cin[i];
      #1;
      vectors++;
      if ({out_a, gate_a} !== {exp[i], 1'b1}) begin
        miscompares++;
        $display("FAIL proto_err cyc %0d: {cen_out,gate}=%b expected %b", i, {out_a, gate_a}, {exp[i], 1'b1});
      end
      adv();
    end
    cen_a = 2'b00;
  endtask

  task automatic test_saturation;
    logic [1:0] e;
    int ne, nq;
    ne = 0; nq = 0;
    busy_a = 2'b10;
    for (int i = 0; i < 80; i++) begin
      cen_a = (i % 2 != 0) ? 2'b00 : (i % 4 == 0) ? 2'b10 : 2'b01;
      #1;
      vectors++;
      if ({out_a, gate_a} !== 3'b000) begin
        miscompares++;
        $display("FAIL sat_stall cyc %0d: {cen_out,gate}=%b expected 000", i, {out_a, gate_a});
      end
      adv();
    end
    busy_a = 2'b00; cen_a = 2'b00;
    for (int i = 0; i < 40; i++) begin
      e = (i >= 30 || i % 2 != 0) ? 2'b00 : (i % 4 == 0) ? 2'b10 : 2'b01;
      #1;
      if (out_a == 2'b10) ne++;
      if (out_a == 2'b01) nq++;
      vectors++;
      if ({out_a, gate_a} !== {e, 1'b1}) begin
        miscompares++;
        $display("FAIL sat_replay cyc %0d: {cen_out,gate}=%b expected %b", i, {out_a, gate_a}, {e, 1'b1});
      end
      adv();
    end
    vectors++;
    if (ne != 8 || nq != 7) begin
      miscompares++;
      $display("FAIL sat_count: E=%0d Q=%0d expected E=8 Q=7", ne, nq);
    end
    cen_a = 2'b01;
    #1;
    vectors++;
    if (out_a !== 2'b01) begin
      miscompares++;
      $display("FAIL sat_after: cen_out=%b expected 01", out_a);
    end
    adv();
    cen_a = 2'b00;
    adv();
  endtask

  task automatic test_rst_recovery;
    logic [1:0] cin [0:3];
    logic [1:0] exp [0:3];
    cin = '{2'b10, 2'b00, 2'b01, 2'b00};
    exp = '{2'b10, 2'b00, 2'b01, 2'b00};
    busy_a = 2'b01;
    for (int i = 0; i < 8; i++) begin
      cen_a = (i % 4 != 0) ? ((i % 4 == 2) ? 2'b01 : 2'b00) : 2'b10;
      if (i == 6) cen_a = 2'b01;
      adv();
    end
    busy_a = 2'b00; cen_a = 2'b00;
    #1;
    vectors++;
    if (out_a !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_rec_first: cen_out=%b expected 10", out_a);
    end
    adv();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cen_a = (i == 0) ? 2'b10 : 2'b00;
      #1;
      vectors++;
      if ({out_a, gate_a} !== 3'b001) begin
        miscompares++;
        $display("FAIL rst_rec_hold cyc %0d: {cen_out,gate}=%b expected 001", i, {out_a, gate_a});
      end
      adv();
    end
    rst = 1'b0; cen_a = 2'b00;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++;
      if (out_a !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_rec_noreplay cyc %0d: cen_out=%b expected 00", i, out_a);
      end
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      cen_a = cin[i];
      #1;
      vectors++;
      if (out_a !== exp[i]) begin
        miscompares++;
        $display("FAIL rst_rec_resume cyc %0d: cen_out=%b expected %b", i, out_a, exp[i]);
      end
      adv();
    end
    cen_a = 2'b00;
  endtask

  task automatic test_no_recovery;
    logic [1:0] cin [0:5];
    logic [1:0] exp [0:5];
    cin = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    exp = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    rom_cs_b = 1'b1; rom_ok_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cen_b = (i % 8 == 0) ? 2'b10 : (i % 8 == 4) ? 2'b01 : 2'b00;
      #1;
      vectors++;
      if ({out_b, gate_b} !== 3'b000) begin
        miscompares++;
        $display("FAIL norec_stall cyc %0d: {cen_out,gate}=%b expected 000", i, {out_b, gate_b});
      end
      adv();
    end
    rom_ok_b = 1'b1; cen_b = 2'b00;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if ({out_b, gate_b} !== 3'b001) begin
        miscompares++;
        $display("FAIL norec_idle cyc %0d: {cen_out,gate}=%b expected 001", i, {out_b, gate_b});
      end
      adv();
    end
    for (int i = 0; i < 6; i++) begin
      cen_b = cin[i];
      #1;
      vectors++;
      if ({out_b, gate_b} !== {exp[i], 1'b1}) begin
        miscompares++;
        $display("FAIL norec_order cyc %0d: {cen_out,gate}=%b expected %b", i, {out_b, gate_b}, {exp[i], 1'b1});
      end
      adv();
    end
    cen_b = 2'b00; rom_cs_b = 1'b0; rom_ok_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_rom_stall();
    test_mismatch();
    test_protocol_error();
    test_saturation();
    test_rst_recovery();
    test_no_recovery();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
